param_sync_ram: RTL and testbench
=================================

// Module: param_sync_ram
// PURPOSE
//  Parametrised single-port synchronous RAM; next generation of the 256x8 decoder/cell RAM.
//  Data width, address width and depth are generic. Reads are registered with a qualified
//  valid. A hardware clear engine zeroes every word after reset and on request.
//  Sits between a CPU-style master (en/rw handshake) and on-chip storage.
// PARAMETERS
//  DATA_W   8            data word width in bits
//  ADDR_W   8            address width in bits
//  DEPTH    1<<ADDR_W    implemented words; must be 1..2**ADDR_W
// PORTS
//  clk       in   1       single clock, rising edge
//  rst_n     in   1       asynchronous active-low reset
//  en        in   1       access request, qualified by ready
//  rw        in   1       1 = read, 0 = write
//  address   in   ADDR_W  word address
//  in        in   DATA_W  write data
//  clr_req   in   1       one-cycle pulse: zero the whole array
//  ready     out  1       1 = access accepted this cycle (state IDLE)
//  out       out  DATA_W  read data, held until the next read completes
//  rd_valid  out  1       one-cycle pulse, out updated with a new read result
//  oob       out  1       one-cycle pulse, accepted access had address >= DEPTH
//  busy      out  1       clear engine running
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): state=INIT, clr_cnt=0, out=0, rd_valid=0, oob=0,
//   ready=0, busy=1. Array contents are not reset directly; the INIT sweep clears them.
//  FSM states:
//   INIT  - writes 0 to word clr_cnt each cycle, clr_cnt++; after word DEPTH-1 -> IDLE.
//           Takes exactly DEPTH cycles after rst_n deasserts.
//   IDLE  - ready=1, busy=0. Accepts one access per cycle when en=1.
//   CLR   - same sweep as INIT, entered from IDLE on clr_req; DEPTH cycles, then -> IDLE.
//  ready and busy are decoded from state; ready = (state==IDLE).
//  Write (en & ready & !rw & address<DEPTH): mem[address]<=in at that edge; no rd_valid.
//  Read (en & ready & rw & address<DEPTH): out<=mem[address] at that edge; rd_valid=1 next cycle.
//   Latency is 1 cycle. Back-to-back reads give back-to-back rd_valid pulses.
//  Out of range (address>=DEPTH, accepted): write is dropped; read returns out=0 with
//   rd_valid=1; oob=1 for one cycle in both cases. Never occurs when DEPTH==2**ADDR_W.
//  en while ready=0 (INIT/CLR): request is dropped with no side effects; the master retries.
//  clr_req in INIT or CLR: ignored; the sweep is not restarted.
//  clr_req and en in the same IDLE cycle: the access completes first, CLR starts next cycle.
//   A read result from that cycle is still delivered, with rd_valid in the first CLR cycle.
//  clr_cnt width is max(1,$clog2(DEPTH)). The counter stops at DEPTH-1 and never wraps into
//   a second sweep.
//  Reset mid-sweep: returns to INIT with clr_cnt=0. The full sweep restarts.
//  out changes only on a completed read, or on reset to 0.
// STRUCTURE
//  Shared package ram_pkg: state enum {INIT, IDLE, CLR} (2 bits); localparam RD=1'b1, WR=1'b0.
//  Sub-module ram_array: DEPTH x DATA_W storage, one write port and one synchronous read port.
//   Controls in it are we, waddr, wdata, re, raddr and rdata; it has no reset.
//  Top level: FSM, clear counter, write mux (clear zero vs user data), range check and
//   the out/rd_valid/oob registers.
// TESTING
//  1 Reset: release rst_n; ready=0 and busy=1 for exactly DEPTH(256) cycles, then ready=1.
//    Read all 256 addresses; each returns 0x00.
//  2 Write/read: write 0xA5@0x10 and 0x3C@0xFF; read 0x10 -> out=0xA5 with rd_valid 1 cycle
//    later. Read 0xFF next cycle -> 0x3C on the back-to-back rd_valid.
//  3 Clear: fill memory with the address value, pulse clr_req; busy=1 for 256 cycles,
//    and en is ignored during it. Afterwards a read of 0x80 -> 0x00.
//  4 Simultaneous: in one IDLE cycle, read 0x10 (holds 0x77) and clr_req=1. rd_valid with
//    0x77 in the next cycle, then busy=1 and a 256-cycle sweep.
//  5 Reset mid-clear: assert rst_n low 100 cycles into CLR. out=0; after release a full
//    256-cycle INIT, then all words read 0.
//  6 DEPTH=200, ADDR_W=8: write 0x55@0xC8 -> oob pulse; read 0xC8 -> out=0, rd_valid=1,
//    oob=1. Read 0xC7 -> its stored value, oob=0.

Source files
------------

// File: rtl/param_sync_ram_pkg.sv
// Shared types and constants for the parametrised synchronous RAM.
// Holds the controller state encoding and the read/write strobe values.
package ram_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        CLR  = 2'd2
    } state_t;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    // Width of the clear counter; never narrower than one bit.
    function automatic int cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_sync_ram_if.sv
// Access bus between a CPU-style master and the synchronous RAM.
// The master issues en/rw requests; the RAM answers with ready and read data.
interface param_sync_ram_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              en;
    logic              rw;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] in;
    logic              clr_req;
    logic              ready;
    logic [DATA_W-1:0] out;
    logic              rd_valid;
    logic              oob;
    logic              busy;

    modport master (
        output en, rw, address, in, clr_req,
        input  ready, out, rd_valid, oob, busy
    );

    modport slave (
        input  en, rw, address, in, clr_req,
        output ready, out, rd_valid, oob, busy
    );
endinterface

// File: rtl/param_sync_ram_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// Holds no reset; contents are initialised by the controller's clear sweep.
module ram_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/param_sync_ram.sv
// Single-port synchronous RAM with registered reads and a hardware clear engine.
// The controller sweeps zeros through the array after reset and on clr_req.
module param_sync_ram
    import ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input logic             clk,
    input logic             rst_n,
    param_sync_ram_if.slave bus
);

    localparam int              CW    = cnt_w(DEPTH);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CW-1:0]   LAST  = CW'(DEPTH - 1);

    state_t            state;
    logic [CW-1:0]     clr_cnt;
    logic              rd_valid_q;
    logic              oob_q;
    logic              zero_q;
    logic              sweep;
    logic              accept;
    logic              in_range;
    logic              is_rd;
    logic              we;
    logic              re;
    logic [CW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    assign sweep    = (state != IDLE);
    assign accept   = bus.en & (state == IDLE);
    assign in_range = ({1'b0, bus.address} < LIMIT);
    assign is_rd    = (bus.rw == RD);

    // The sweep owns the write port whenever the controller is not idle.
    assign we    = sweep | (accept & ~is_rd & in_range);
    assign waddr = sweep ? clr_cnt : bus.address[CW-1:0];
    assign wdata = sweep ? '0 : bus.in;
    assign re    = accept & is_rd & in_range;

    ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (CW)
    ) u_array (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re    (re),
        .raddr (bus.address[CW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            clr_cnt    <= '0;
            rd_valid_q <= 1'b0;
            oob_q      <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            rd_valid_q <= accept & is_rd;
            oob_q      <= accept & ~in_range;
            // zero_q masks the array output after reset and for out-of-range reads.
            if (accept & is_rd)
                zero_q <= ~in_range;
            unique case (state)
                INIT, CLR: begin
                    if (clr_cnt == LAST) begin
                        state   <= IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (bus.clr_req)
                        state <= CLR;
                end
                default: begin
                    state   <= INIT;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.busy     = sweep;
    assign bus.out      = zero_q ? '0 : rdata;
    assign bus.rd_valid = rd_valid_q;
    assign bus.oob      = oob_q;

endmodule

// File: tb/tb_param_sync_ram.sv
// Directed bench for param_sync_ram: a full-depth instance and a DEPTH=200 one.
// Table-driven access vectors plus hand-written clear/reset sequences.
module tb_param_sync_ram;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    param_sync_ram_if #(.DATA_W(8), .ADDR_W(8)) bus ();
    param_sync_ram_if #(.DATA_W(8), .ADDR_W(8)) bus2 ();

    param_sync_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    param_sync_ram #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         sel;
        bit         rw;
        logic [7:0] addr;
        logic [7:0] din;
        logic [7:0] exp_out;
        bit         exp_vld;
        bit         exp_oob;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit en, input bit rw,
                         input logic [7:0] a, input logic [7:0] d);
        bus.en       = en & ~sel;
        bus2.en      = en & sel;
        bus.rw       = rw;
        bus2.rw      = rw;
        bus.address  = a;
        bus2.address = a;
        bus.in       = d;
        bus2.in      = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        bus.clr_req  = 1'b0;
        bus2.clr_req = 1'b0;
    endtask

    // Counts edges after reset release until each instance reports ready.
    task automatic measure_init(input string tag);
        int c1 = 0;
        int c2 = 0;
        for (int k = 1; k <= 400; k++) begin
            @(posedge clk); #1;
            if (c1 == 0 && bus.ready) c1 = k;
            if (c2 == 0 && bus2.ready) c2 = k;
        end
        check({tag, "_len256"}, c1, 256);
        check({tag, "_len200"}, c2, 200);
    endtask

    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(a), 8'h00);
            @(posedge clk); #1;
            check({tag, "_out"}, bus.out, 0);
            check({tag, "_vld"}, bus.rd_valid, 1);
        end
        idle();
    endtask

    // Counts cycles with busy high, starting just after the edge that entered CLR.
    task automatic count_busy(input string tag, input bit poke);
        int c = 0;
        while (bus.busy && c < 1000) begin
            if (poke) drive(1'b0, 1'b1, 1'b0, 8'h80, 8'hFF);
            @(posedge clk); #1;
            c++;
            if (!bus.busy) idle();
        end
        idle();
        check({tag, "_busy_len"}, c, 256);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();

        vecs[0]  = '{0, 0, 8'h10, 8'hA5, 8'h00, 0, 0};
        vecs[1]  = '{0, 0, 8'hFF, 8'h3C, 8'h00, 0, 0};
        vecs[2]  = '{0, 1, 8'h10, 8'h00, 8'hA5, 1, 0};
        vecs[3]  = '{0, 1, 8'hFF, 8'h00, 8'h3C, 1, 0};
        vecs[4]  = '{0, 1, 8'h00, 8'h00, 8'h00, 1, 0};
        vecs[5]  = '{1, 0, 8'hC7, 8'h11, 8'h00, 0, 0};
        vecs[6]  = '{1, 0, 8'hC8, 8'h55, 8'h00, 0, 1};
        vecs[7]  = '{1, 1, 8'hC8, 8'h00, 8'h00, 1, 1};
        vecs[8]  = '{1, 1, 8'hC7, 8'h00, 8'h11, 1, 0};
        vecs[9]  = '{1, 1, 8'hC8, 8'h00, 8'h00, 1, 1};
        vecs[10] = '{1, 0, 8'h00, 8'hEE, 8'h00, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.ready, 0);
        check("rst_busy", bus.busy, 1);
        check("rst_out", bus.out, 0);
        check("rst_vld", bus.rd_valid, 0);
        check("rst_oob", bus.oob, 0);

        rst_n = 1'b1;
        measure_init("init");
        read_all_zero("init_rd");

        // Back-to-back access vectors on both instances
        foreach (vecs[i]) begin
            drive(vecs[i].sel, 1'b1, vecs[i].rw, vecs[i].addr, vecs[i].din);
            @(posedge clk); #1;
            if (vecs[i].sel) begin
                check($sformatf("vec%0d_out", i), bus2.out, vecs[i].exp_out);
                check($sformatf("vec%0d_vld", i), bus2.rd_valid, vecs[i].exp_vld);
                check($sformatf("vec%0d_oob", i), bus2.oob, vecs[i].exp_oob);
            end else begin
                check($sformatf("vec%0d_out", i), bus.out, vecs[i].exp_out);
                check($sformatf("vec%0d_vld", i), bus.rd_valid, vecs[i].exp_vld);
                check($sformatf("vec%0d_oob", i), bus.oob, vecs[i].exp_oob);
            end
        end
        idle();
        @(posedge clk); #1;
        check("vld_drop", bus.rd_valid, 0);

        // Clear engine with writes attempted throughout the sweep
        for (int a = 0; a < 256; a++) begin
            drive(1'b0, 1'b1, 1'b0, 8'(a), 8'(a));
            @(posedge clk); #1;
        end
        idle();
        drive(1'b0, 1'b1, 1'b1, 8'h80, 8'h00);
        @(posedge clk); #1;
        check("fill_rd80", bus.out, 8'h80);
        idle();
        bus.clr_req = 1'b1;
        @(posedge clk); #1;
        bus.clr_req = 1'b0;
        check("clr_ready", bus.ready, 0);
        count_busy("clr", 1'b1);
        drive(1'b0, 1'b1, 1'b1, 8'h80, 8'h00);
        @(posedge clk); #1;
        check("clr_rd80", bus.out, 0);
        drive(1'b0, 1'b1, 1'b1, 8'h81, 8'h00);
        @(posedge clk); #1;
        check("clr_rd81", bus.out, 0);
        idle();

        // Read and clr_req in the same idle cycle
        drive(1'b0, 1'b1, 1'b0, 8'h10, 8'h77);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 8'h10, 8'h00);
        bus.clr_req = 1'b1;
        @(posedge clk); #1;
        idle();
        check("sim_vld", bus.rd_valid, 1);
        check("sim_out", bus.out, 8'h77);
        check("sim_busy", bus.busy, 1);
        count_busy("sim", 1'b0);
        check("sim_out_hold", bus.out, 8'h77);

        // Reset in the middle of a clear sweep
        drive(1'b0, 1'b1, 1'b0, 8'h20, 8'h99);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b1, 8'h20, 8'h00);
        @(posedge clk); #1;
        idle();
        check("mid_pre_out", bus.out, 8'h99);
        bus.clr_req = 1'b1;
        @(posedge clk); #1;
        bus.clr_req = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", bus.out, 0);
        check("mid_rst_ready", bus.ready, 0);
        check("mid_rst_busy", bus.busy, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        measure_init("mid");
        read_all_zero("mid_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
